// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  localparam logic [1:0] TGT_PC_IMM = 2'b00;
  localparam logic [1:0] TGT_ALU    = 2'b01;
  localparam logic [1:0] TGT_SEQ    = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/next_pc_gen.sv
// Next fetch address selection from the control path's redirect outputs.
module next_pc_gen
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            PCSrc,
  input  logic [1:0]      TargetSrc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  always_comb begin
    next_pc = pc + XLEN'(4);
    if (PCSrc) begin
      case (TargetSrc)
        TGT_ALU: next_pc = alu_result & ~XLEN'(1);
        TGT_SEQ: next_pc = pc + XLEN'(4);
        // reserved encoding 2'b11 behaves like a branch/JAL target
        default: next_pc = pc + imm_ext;
      endcase
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: one outstanding word request, holds the
// fetched instruction until retire, then steers the PC from the control path.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ready,
  input  logic            PCSrc,
  input  logic [1:0]      TargetSrc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_misaligned,
  output logic [2:0]      dbg_state
);
  // Memory handshake: a request is accepted in the cycle imem_req && imem_gnt;
  // imem_addr is held until then. Decode handshake: an instruction retires in
  // the cycle instr_valid && instr_ready; instr/pc are held until then.

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
    .pc         (pc),
    .PCSrc      (PCSrc),
    .TargetSrc  (TargetSrc),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      imem_req         <= 1'b0;
      imem_addr        <= RESET_PC;
      instr_valid      <= 1'b0;
      instr            <= NOP_INSTR;
      pc               <= RESET_PC;
      pc_plus4         <= RESET_PC + 32'd4;
      fetch_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state       <= HOLD;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            pc_plus4    <= next_pc + XLEN'(4);
            // a misaligned target parks the unit with pc pointing at it
            if (next_misaligned) begin
              state            <= HALT;
              fetch_misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= next_pc;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
